// File: rtl/passive_entry_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// passive_pkg
// Shared definitions for the passive-entry controller:
//   - state_e      : state encoding, also exported on state_o for the monitor
//   - *_DEF        : default parameter values used by the top level
//   - fail_sat_inc : saturating increment for the failed-attempt counter
// Optional feature macro used by the design: PASSIVE_LOCKOUT_EN
// -----------------------------------------------------------------------------
package passive_pkg;

    typedef enum logic [2:0] {
        LOCKED   = 3'd0,
        WELCOME  = 3'd1,
        UNLOCKED = 3'd2,
        IGN_ON   = 3'd3,
        LOCKOUT  = 3'd4
    } state_e;

    localparam int DEBOUNCE_CYC_DEF   = 4;
    localparam int LIGHT_HOLD_DEF     = 8;
    localparam int UNLOCK_TIMEOUT_DEF = 16;
    localparam int MAX_FAIL_DEF       = 3;
    localparam int LOCKOUT_CYC_DEF    = 32;
    localparam int CNT_W_DEF          = 6;

    // Counter stops at max so it never wraps back to zero.
    function automatic logic [1:0] fail_sat_inc(input logic [1:0] cnt,
                                                 input logic [1:0] max);
        return (cnt >= max) ? cnt : cnt + 2'd1;
    endfunction

endpackage

// File: rtl/passive_entry_ctrl_if.sv
// -----------------------------------------------------------------------------
// passive_entry_ctrl_if
// Bundles the fob/button inputs and the car-body outputs of the controller.
//   PassiveSignal_s   : fob in range (raw)          master -> slave
//   PassiveSignal_b   : start button (raw)          master -> slave
//   CarLightsOnSign   : exterior lights             slave  -> master
//   OpenDoorSign      : doors unlocked              slave  -> master
//   IgnitionSignalOn  : ignition enabled            slave  -> master
//   state_o[2:0]      : current state code          slave  -> master
//   fail_cnt_o[1:0]   : failed-attempt count        slave  -> master
// The controller connects through the slave modport; the front end / tester
// uses the master modport.
// -----------------------------------------------------------------------------
interface passive_entry_ctrl_if;

    logic       PassiveSignal_s;
    logic       PassiveSignal_b;
    logic       CarLightsOnSign;
    logic       OpenDoorSign;
    logic       IgnitionSignalOn;
    logic [2:0] state_o;
    logic [1:0] fail_cnt_o;

    modport master (
        output PassiveSignal_s,
        output PassiveSignal_b,
        input  CarLightsOnSign,
        input  OpenDoorSign,
        input  IgnitionSignalOn,
        input  state_o,
        input  fail_cnt_o
    );

    modport slave (
        input  PassiveSignal_s,
        input  PassiveSignal_b,
        output CarLightsOnSign,
        output OpenDoorSign,
        output IgnitionSignalOn,
        output state_o,
        output fail_cnt_o
    );

endinterface

// File: rtl/passive_entry_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// passive_debounce
// Registers one raw input, then requires DEBOUNCE_CYC consecutive high
// registered samples before asserting valid_o. A single low sample clears
// both the counter and valid_o on that edge.
// Ports:
//   clk      : clock, posedge
//   reset_L  : synchronous active-low reset
//   raw_i    : raw asynchronous-ish input
//   valid_o  : debounced level
// -----------------------------------------------------------------------------
module passive_debounce #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
    input  logic clk,
    input  logic reset_L,
    input  logic raw_i,
    output logic valid_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_CYC);

    logic             raw_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count saturates at the threshold so a long press stays valid.
    always_comb begin
        cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            raw_q   <= 1'b0;
            cnt_q   <= '0;
            valid_o <= 1'b0;
        end else begin
            raw_q <= raw_i;
            if (!raw_q) begin
                cnt_q   <= '0;
                valid_o <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                valid_o <= (cnt_d == CNT_FULL);
            end
        end
    end

endmodule

// File: rtl/passive_entry_ctrl.sv
// -----------------------------------------------------------------------------
// passive_entry_ctrl
// Keyless-entry sequencing controller. Debounces the fob-proximity and start
// button inputs, then walks LOCKED -> WELCOME (lights) -> UNLOCKED (lights +
// doors) -> IGN_ON (lights + ignition), with timed auto-relock and a
// failed-attempt counter.
// Ports:
//   clk      : clock, posedge
//   reset_L  : synchronous active-low reset
//   bus      : passive_entry_ctrl_if.slave (raw inputs, car-body outputs,
//              state_o and fail_cnt_o for the monitor)
// Optional feature macro: PASSIVE_LOCKOUT_EN
//   defined   : MAX_FAIL button presses without fob enter LOCKOUT for
//               LOCKOUT_CYC cycles (lights blink, inputs ignored).
//   undefined : LOCKOUT is never entered; code 4 recovers to LOCKED.
// -----------------------------------------------------------------------------
module passive_entry_ctrl
    import passive_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
    parameter int LIGHT_HOLD     = LIGHT_HOLD_DEF,
    parameter int UNLOCK_TIMEOUT = UNLOCK_TIMEOUT_DEF,
    parameter int MAX_FAIL       = MAX_FAIL_DEF,
    parameter int LOCKOUT_CYC    = LOCKOUT_CYC_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_L,
    passive_entry_ctrl_if.slave   bus
);

    localparam int T_MAX_A = (LIGHT_HOLD > UNLOCK_TIMEOUT) ? LIGHT_HOLD : UNLOCK_TIMEOUT;
    localparam int T_MAX   = (T_MAX_A > LOCKOUT_CYC) ? T_MAX_A : LOCKOUT_CYC;

    // The shared timer must be able to represent the longest timed interval.
    if ((2 ** CNT_W) <= T_MAX) begin : g_cnt_w_check
        $error("CNT_W too narrow for the longest timed state");
    end

    localparam logic [CNT_W-1:0] WELCOME_LAST = CNT_W'(LIGHT_HOLD - 1);
    localparam logic [CNT_W-1:0] UNLOCK_LAST  = CNT_W'(UNLOCK_TIMEOUT - 1);
`ifdef PASSIVE_LOCKOUT_EN
    localparam logic [CNT_W-1:0] LOCKOUT_LAST = CNT_W'(LOCKOUT_CYC - 1);
`endif
    localparam logic [1:0]       MAX_FAIL_C   = 2'(MAX_FAIL);

    // ---------------------------------------------------------------------
    // Input conditioning: index 0 = fob (_s), index 1 = button (_b)
    // ---------------------------------------------------------------------
    logic [1:0] raw_vec;
    logic [1:0] valid_vec;

    assign raw_vec = {bus.PassiveSignal_b, bus.PassiveSignal_s};

    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        passive_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CNT_W        ($clog2(DEBOUNCE_CYC + 1))
        ) u_deb (
            .clk     (clk),
            .reset_L (reset_L),
            .raw_i   (raw_vec[gi]),
            .valid_o (valid_vec[gi])
        );
    end

    logic s_v;
    logic b_v;
    logic b_v_q;
    logic b_rise;
    logic [1:0] fail_inc;

    assign s_v      = valid_vec[0];
    assign b_v      = valid_vec[1];
    assign b_rise   = b_v & ~b_v_q;

    // ---------------------------------------------------------------------
    // State machine with registered outputs
    // ---------------------------------------------------------------------
    state_e           state_q;
    logic [CNT_W-1:0] timer_q;
    logic [1:0]       fail_q;
    logic             lights_q;
    logic             door_q;
    logic             ign_q;

    assign fail_inc = fail_sat_inc(fail_q, MAX_FAIL_C);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q  <= LOCKED;
            timer_q  <= '0;
            fail_q   <= 2'd0;
            b_v_q    <= 1'b0;
            lights_q <= 1'b0;
            door_q   <= 1'b0;
            ign_q    <= 1'b0;
        end else begin
            b_v_q <= b_v;
            case (state_q)
                LOCKED: begin
                    timer_q  <= '0;
                    lights_q <= 1'b0;
                    door_q   <= 1'b0;
                    ign_q    <= 1'b0;
                    // Fob presence wins over a simultaneous press.
                    if (s_v) begin
                        state_q  <= WELCOME;
                        fail_q   <= 2'd0;
                        lights_q <= 1'b1;
                    end else if (b_rise) begin
                        fail_q <= fail_inc;
`ifdef PASSIVE_LOCKOUT_EN
                        if (fail_inc == MAX_FAIL_C) begin
                            state_q <= LOCKOUT;
                        end
`endif
                    end
                end

                WELCOME: begin
                    door_q <= 1'b0;
                    ign_q  <= 1'b0;
                    if (!s_v) begin
                        state_q  <= LOCKED;
                        timer_q  <= '0;
                        lights_q <= 1'b0;
                    end else if (timer_q == WELCOME_LAST) begin
                        state_q  <= UNLOCKED;
                        timer_q  <= '0;
                        lights_q <= 1'b1;
                        door_q   <= 1'b1;
                    end else begin
                        timer_q  <= timer_q + CNT_W'(1);
                        lights_q <= 1'b1;
                    end
                end

                UNLOCKED: begin
                    // A press only counts while the fob is present; losing
                    // the fob does not restart the relock countdown.
                    if (b_rise && s_v) begin
                        state_q  <= IGN_ON;
                        timer_q  <= '0;
                        lights_q <= 1'b1;
                        door_q   <= 1'b0;
                        ign_q    <= 1'b1;
                    end else if (timer_q == UNLOCK_LAST) begin
                        state_q  <= LOCKED;
                        timer_q  <= '0;
                        lights_q <= 1'b0;
                        door_q   <= 1'b0;
                        ign_q    <= 1'b0;
                    end else begin
                        timer_q  <= timer_q + CNT_W'(1);
                        lights_q <= 1'b1;
                        door_q   <= 1'b1;
                        ign_q    <= 1'b0;
                    end
                end

                IGN_ON: begin
                    // Ignition is never dropped on fob loss; only a press exits.
                    timer_q <= '0;
                    if (b_rise) begin
                        state_q  <= UNLOCKED;
                        lights_q <= 1'b1;
                        door_q   <= 1'b1;
                        ign_q    <= 1'b0;
                    end else begin
                        lights_q <= 1'b1;
                        door_q   <= 1'b0;
                        ign_q    <= 1'b1;
                    end
                end

`ifdef PASSIVE_LOCKOUT_EN
                LOCKOUT: begin
                    door_q <= 1'b0;
                    ign_q  <= 1'b0;
                    if (timer_q == LOCKOUT_LAST) begin
                        state_q  <= LOCKED;
                        timer_q  <= '0;
                        fail_q   <= 2'd0;
                        lights_q <= 1'b0;
                    end else begin
                        timer_q  <= timer_q + CNT_W'(1);
                        // Blink follows bit 0 of the next timer value.
                        lights_q <= ~timer_q[0];
                    end
                end
`endif

                default: begin
                    state_q  <= LOCKED;
                    timer_q  <= '0;
                    lights_q <= 1'b0;
                    door_q   <= 1'b0;
                    ign_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CarLightsOnSign  = lights_q;
    assign bus.OpenDoorSign     = door_q;
    assign bus.IgnitionSignalOn = ign_q;
    assign bus.state_o          = state_q;
    assign bus.fail_cnt_o       = fail_q;

endmodule

// File: tb/tb_passive_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_passive_entry_ctrl
// Self-checking bench for passive_entry_ctrl: directed scenarios plus a long
// randomized run, all compared cycle by cycle against a behavioural model.
// Optional feature macro: PASSIVE_LOCKOUT_EN (changes lockout expectations).
// -----------------------------------------------------------------------------
module tb_passive_entry_ctrl;

    localparam int DB = 4;
    localparam int LH = 8;
    localparam int UT = 16;
    localparam int MF = 3;
    localparam int LC = 32;
`ifdef PASSIVE_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    passive_entry_ctrl_if bus_if ();

    passive_entry_ctrl dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    // Debounced level = input sampled high on the previous DB edges with no
    // reset over the window; states advance on elapsed-edge counts.
    int n      = 0;
    int m_st   = 0;
    int m_ent  = 0;
    int m_fail = 0;
    bit m_sv   = 1'b0;
    bit m_bv   = 1'b0;
    bit m_bvp  = 1'b0;
    bit hs[DB+1];
    bit hb[DB+1];
    bit hr[DB+1];

    task automatic model_edge(input bit rst_n, input bit s, input bit b);
        bit sv_new, bv_new, br, sv;
        n++;
        for (int i = DB; i > 0; i--) begin
            hs[i] = hs[i-1];
            hb[i] = hb[i-1];
            hr[i] = hr[i-1];
        end
        hs[0] = s;
        hb[0] = b;
        hr[0] = !rst_n;
        sv_new = 1'b1;
        bv_new = 1'b1;
        for (int i = 0; i <= DB; i++) begin
            if (hr[i]) begin
                sv_new = 1'b0;
                bv_new = 1'b0;
            end
        end
        for (int i = 1; i <= DB; i++) begin
            if (!hs[i]) sv_new = 1'b0;
            if (!hb[i]) bv_new = 1'b0;
        end
        sv = m_sv;
        br = m_bv && !m_bvp;
        if (!rst_n) begin
            m_st = 0; m_ent = n; m_fail = 0;
        end else begin
            case (m_st)
                0: begin
                    if (sv) begin
                        m_st = 1; m_ent = n; m_fail = 0;
                    end else if (br) begin
                        m_fail = (m_fail < MF) ? m_fail + 1 : MF;
                        if (LOCK_EN && m_fail == MF) begin
                            m_st = 4; m_ent = n;
                        end
                    end
                end
                1: begin
                    if (!sv) begin m_st = 0; m_ent = n; end
                    else if (n - m_ent == LH) begin m_st = 2; m_ent = n; end
                end
                2: begin
                    if (br && sv) begin m_st = 3; m_ent = n; end
                    else if (n - m_ent == UT) begin m_st = 0; m_ent = n; end
                end
                3: begin
                    if (br) begin m_st = 2; m_ent = n; end
                end
                4: begin
                    if (n - m_ent == LC) begin m_st = 0; m_ent = n; m_fail = 0; end
                end
                default: begin m_st = 0; m_ent = n; end
            endcase
        end
        m_bvp = rst_n ? m_bv : 1'b0;
        m_sv  = sv_new;
        m_bv  = bv_new;
    endtask

    function automatic logic [7:0] exp_vec();
        logic l, d, g;
        l = 1'b0; d = 1'b0; g = 1'b0;
        case (m_st)
            1: l = 1'b1;
            2: begin l = 1'b1; d = 1'b1; end
            3: begin l = 1'b1; g = 1'b1; end
            4: l = (((n - m_ent) % 2) == 1);
            default: ;
        endcase
        return {3'(m_st), l, d, g, 2'(m_fail)};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {bus_if.state_o, bus_if.CarLightsOnSign, bus_if.OpenDoorSign,
                bus_if.IgnitionSignalOn, bus_if.fail_cnt_o};
    endfunction

    // One clock edge: capture the inputs the DUT samples, then settle.
    task automatic step();
        bit r, s, b;
        r = reset_L;
        s = bus_if.PassiveSignal_s;
        b = bus_if.PassiveSignal_b;
        @(posedge clk);
        #1;
        model_edge(r, s, b);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_L = 1'b0;
        bus_if.PassiveSignal_s = 1'b1;
        bus_if.PassiveSignal_b = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (dut_vec() !== 8'h00) begin
                errors++;
                $display("FAIL reset_state edge %0d got %b exp %b", n, dut_vec(), 8'h00);
            end
        end
        bus_if.PassiveSignal_s = 1'b0;
        bus_if.PassiveSignal_b = 1'b0;
        step();
        reset_L = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_release edge %0d got %b exp %b", n, dut_vec(), exp_vec());
            end
        end
        $display("test_reset done at edge %0d", n);
    endtask

    task automatic test_fob_approach();
        bus_if.PassiveSignal_s = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fob_model edge %0d got %b exp %b", n, dut_vec(), exp_vec());
            end
            if (k == 5) begin
                checks++;
                if (bus_if.state_o !== 3'd0) begin
                    errors++;
                    $display("FAIL fob_still_locked k=5 got %0d exp 0", bus_if.state_o);
                end
            end
            if (k == 6 || k == 13) begin
                checks++;
                if (dut_vec() !== 8'b001_100_00) begin
                    errors++;
                    $display("FAIL fob_welcome k=%0d got %b exp %b", k, dut_vec(), 8'b001_100_00);
                end
            end
            if (k == 14) begin
                checks++;
                if (dut_vec() !== 8'b010_110_00) begin
                    errors++;
                    $display("FAIL fob_unlocked k=14 got %b exp %b", dut_vec(), 8'b010_110_00);
                end
            end
        end
        $display("test_fob_approach done at edge %0d", n);
    endtask

    task automatic test_start();
        int k;
        bus_if.PassiveSignal_b = 1'b1;
        k = 0;
        do begin
            step();
            k++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL start_model edge %0d got %b exp %b", n, dut_vec(), exp_vec());
            end
        end while (bus_if.state_o !== 3'd3 && k < 12);
        checks++;
        if (k != 6 || dut_vec() !== 8'b011_101_00) begin
            errors++;
            $display("FAIL start_ign_on edges %0d outs %b exp 6 %b", k, dut_vec(), 8'b011_101_00);
        end
        bus_if.PassiveSignal_b = 1'b0;
        repeat (2) step();
        bus_if.PassiveSignal_b = 1'b1;
        k = 0;
        do begin
            step();
            k++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL start_model2 edge %0d got %b exp %b", n, dut_vec(), exp_vec());
            end
        end while (bus_if.state_o !== 3'd2 && k < 12);
        checks++;
        if (k != 6 || dut_vec() !== 8'b010_110_00) begin
            errors++;
            $display("FAIL start_second_press edges %0d outs %b exp 6 %b", k, dut_vec(), 8'b010_110_00);
        end
        bus_if.PassiveSignal_b = 1'b0;
        $display("test_start done at edge %0d", n);
    endtask

    task automatic test_timeout();
        int k;
        for (k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL timeout_model edge %0d got %b exp %b", n, dut_vec(), exp_vec());
            end
            if (k == 15) begin
                checks++;
                if (bus_if.state_o !== 3'd2) begin
                    errors++;
                    $display("FAIL timeout_early k=15 got %0d exp 2", bus_if.state_o);
                end
            end
            if (k == 16) begin
                checks++;
                if (dut_vec() !== 8'h00) begin
                    errors++;
                    $display("FAIL timeout_relock k=16 got %b exp %b", dut_vec(), 8'h00);
                end
            end
        end
        repeat (3) step();
        checks++;
        if (bus_if.state_o !== 3'd1) begin
            errors++;
            $display("FAIL rewelcome got %0d exp 1", bus_if.state_o);
        end
        bus_if.PassiveSignal_s = 1'b0;
        k = 0;
        do begin
            step();
            k++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drop_model edge %0d got %b exp %b", n, dut_vec(), exp_vec());
            end
        end while (bus_if.state_o !== 3'd0 && k < 8);
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL welcome_drop_latency got %0d exp 3", k);
        end
        $display("test_timeout done at edge %0d", n);
    endtask

    task automatic test_fail_lockout();
        int e;
        bus_if.PassiveSignal_s = 1'b0;
        bus_if.PassiveSignal_b = 1'b0;
        repeat (2) step();
        for (int p = 0; p < 3; p++) begin
            bus_if.PassiveSignal_b = 1'b1;
            for (int k = 0; k < 6; k++) begin
                step();
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL fail_model edge %0d got %b exp %b", n, dut_vec(), exp_vec());
                end
            end
            checks++;
            if (bus_if.fail_cnt_o !== 2'(p + 1)) begin
                errors++;
                $display("FAIL fail_count press %0d got %0d exp %0d", p + 1, bus_if.fail_cnt_o, p + 1);
            end
            bus_if.PassiveSignal_b = 1'b0;
            if (p < 2) repeat (2) step();
        end
`ifdef PASSIVE_LOCKOUT_EN
        checks++;
        if (bus_if.state_o !== 3'd4 || bus_if.CarLightsOnSign !== 1'b0) begin
            errors++;
            $display("FAIL lockout_entry state %0d lights %b exp 4 0", bus_if.state_o, bus_if.CarLightsOnSign);
        end
        e = 0;
        do begin
            step();
            e++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL lockout_model edge %0d got %b exp %b", n, dut_vec(), exp_vec());
            end
            if (bus_if.state_o == 3'd4) begin
                checks++;
                if (bus_if.CarLightsOnSign !== 1'(e % 2)) begin
                    errors++;
                    $display("FAIL lockout_blink e=%0d got %b exp %b", e, bus_if.CarLightsOnSign, 1'(e % 2));
                end
            end
        end while (bus_if.state_o == 3'd4 && e < 40);
        checks++;
        if (e != LC || dut_vec() !== 8'h00) begin
            errors++;
            $display("FAIL lockout_exit edges %0d outs %b exp %0d %b", e, dut_vec(), LC, 8'h00);
        end
`else
        e = 0;
        checks++;
        if (bus_if.state_o !== 3'd0 || bus_if.fail_cnt_o !== 2'd3) begin
            errors++;
            $display("FAIL no_lockout state %0d fail %0d exp 0 3", bus_if.state_o, bus_if.fail_cnt_o);
        end
        repeat (2) step();
        bus_if.PassiveSignal_b = 1'b1;
        repeat (6) begin
            step();
            e++;
        end
        checks++;
        if (dut_vec() !== exp_vec() || bus_if.fail_cnt_o !== 2'd3) begin
            errors++;
            $display("FAIL fail_saturate after %0d edges got %b exp %b", e, dut_vec(), exp_vec());
        end
        bus_if.PassiveSignal_b = 1'b0;
        repeat (2) step();
`endif
        $display("test_fail_lockout done at edge %0d", n);
    endtask

    task automatic test_reset_mid_ign();
        int k;
        bus_if.PassiveSignal_s = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (bus_if.state_o !== 3'd2 && k < 24);
        bus_if.PassiveSignal_b = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (bus_if.state_o !== 3'd3 && k < 12);
        checks++;
        if (dut_vec() !== exp_vec() || bus_if.state_o !== 3'd3) begin
            errors++;
            $display("FAIL reach_ign_on got %b exp %b", dut_vec(), exp_vec());
        end
        bus_if.PassiveSignal_b = 1'b0;
        step();
        reset_L = 1'b0;
        step();
        checks++;
        if (dut_vec() !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_ign got %b exp %b", dut_vec(), 8'h00);
        end
        reset_L = 1'b1;
        bus_if.PassiveSignal_s = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL after_reset_model edge %0d got %b exp %b", n, dut_vec(), exp_vec());
            end
        end
        $display("test_reset_mid_ign done at edge %0d", n);
    endtask

    task automatic test_random();
        int s_run, b_run, r_run;
        s_run = 0; b_run = 0; r_run = 0;
        for (int c = 0; c < 3000; c++) begin
            if (r_run > 0) begin
                r_run--;
                if (r_run == 0) reset_L = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                reset_L = 1'b0;
                r_run = int'($urandom_range(1, 2));
            end
            if (s_run == 0) begin
                bus_if.PassiveSignal_s = ($urandom_range(0, 2) != 0);
                s_run = int'($urandom_range(1, 40));
            end
            s_run--;
            if (b_run == 0) begin
                bus_if.PassiveSignal_b = ($urandom_range(0, 1) != 0);
                b_run = int'($urandom_range(1, 10));
            end
            b_run--;
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random edge %0d got %b exp %b", n, dut_vec(), exp_vec());
            end
        end
        reset_L = 1'b1;
        $display("test_random done at edge %0d", n);
    endtask

    initial begin
        for (int i = 0; i <= DB; i++) begin
            hs[i] = 1'b0;
            hb[i] = 1'b0;
            hr[i] = 1'b1;
        end
        bus_if.PassiveSignal_s = 1'b0;
        bus_if.PassiveSignal_b = 1'b0;
        test_reset();
        test_fob_approach();
        test_start();
        test_timeout();
        test_fail_lockout();
        test_reset_mid_ign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
